// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone arbiter (m0 = fetch, m1 = load/store), no preemption.
// Define WB_ARBITER_TIMEOUT_EN to add a slave watchdog that errors out stalled transfers.
module wb_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            arb_clk_i,
  input  logic            arb_rst_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic [DW-1:0]   m0_dat_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [DW-1:0]   m1_dat_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic [DW-1:0]   s_dat_i
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e            state_q;
  logic              lp_q;
  logic              own0, own1, own, to_hit;
  logic              mc, ms, mw;
  logic [AW-1:0]     ma;
  logic [DW-1:0]     md;
  logic [DW/8-1:0]   mse;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_arbiter: TIMEOUT_CYCLES must be within 1..65535");
  end

  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);
  assign own  = own0 | own1;

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] to_q, to_d;

  assign to_hit = own && (to_q == TO_LIM);

  // Counter is zero throughout IDLE, so every grant starts from a clean count.
  always_comb begin
    to_d = to_q;
    if (!own || to_hit || s_ack_i || s_err_i) to_d = '0;
    else if (s_stb_o)                         to_d = to_q + 16'd1;
  end

  always_ff @(posedge arb_clk_i or negedge arb_rst_i) begin
    if (!arb_rst_i) to_q <= '0;
    else            to_q <= to_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    if (own1) begin
      mc = m1_cyc_i; ms = m1_stb_i; mw = m1_we_i;
      ma = m1_adr_i; md = m1_dat_i; mse = m1_sel_i;
    end else begin
      mc = m0_cyc_i; ms = m0_stb_i; mw = m0_we_i;
      ma = m0_adr_i; md = m0_dat_i; mse = m0_sel_i;
    end
  end

  // State resets asynchronously, so all of these collapse to idle values with reset.
  assign s_cyc_o  = own & mc & ~to_hit;
  assign s_stb_o  = own & ms & ~to_hit;
  assign s_we_o   = own & mw;
  assign s_adr_o  = own ? ma  : '0;
  assign s_dat_o  = own ? md  : '0;
  assign s_sel_o  = own ? mse : '0;

  assign m0_ack_o = own0 & s_ack_i & ~to_hit;
  assign m0_err_o = own0 & (s_err_i | to_hit);
  assign m1_ack_o = own1 & s_ack_i & ~to_hit;
  assign m1_err_o = own1 & (s_err_i | to_hit);
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // lp_q tracks the last granted master; contention goes to the other one.
  always_ff @(posedge arb_clk_i or negedge arb_rst_i) begin
    if (!arb_rst_i) begin
      state_q <= IDLE;
      lp_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || lp_q)) begin
            state_q <= OWN0;
            lp_q    <= 1'b0;
          end else if (m1_cyc_i) begin
            state_q <= OWN1;
            lp_q    <= 1'b1;
          end
        end
        OWN0:    if (!m0_cyc_i || to_hit) state_q <= IDLE;
        OWN1:    if (!m1_cyc_i || to_hit) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
